// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, FSM state type and a helper for slicing
// flattened per-port vectors used by the multi-port register file.
package regfile_pkg;

  localparam int DEFAULT_WORD_WIDTH  = 32;
  localparam int DEFAULT_REG_NUM     = 32;
  localparam int DEFAULT_REG_NUM_LOG = 5;

  // INIT sweeps the array to zero after reset, RUN is normal operation.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // LSB position of port `port` inside a flattened vector of `width`-bit fields.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port. Decodes the address,
// muxes the array and the busy bit, and forces zero outside RUN and for x0.
// With REGFILE_BYPASS_EN defined, an accepted same-cycle write to the
// addressed register is forwarded (highest-index write port wins).
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WORD_WIDTH  = DEFAULT_WORD_WIDTH,
  parameter int REG_NUM     = DEFAULT_REG_NUM,
`ifdef REGFILE_BYPASS_EN
  parameter int WRITE_PORTS = 2,
`endif
  parameter int REG_NUM_LOG = DEFAULT_REG_NUM_LOG
) (
  input  state_t                 i_state,
  input  logic [REG_NUM_LOG-1:0] i_addr,
  input  logic [WORD_WIDTH-1:0]  i_regs [REG_NUM],
  input  logic [REG_NUM-1:0]     i_busy,
`ifdef REGFILE_BYPASS_EN
  input  logic [WRITE_PORTS-1:0] i_wr_ok,
  input  logic [REG_NUM_LOG-1:0] i_wr_addr [WRITE_PORTS],
  input  logic [WORD_WIDTH-1:0]  i_wr_value [WRITE_PORTS],
  input  logic                   i_bset_en,
  input  logic [REG_NUM_LOG-1:0] i_bset_addr,
`endif
  output logic [WORD_WIDTH-1:0]  o_value,
  output logic                   o_busy
);

  // Array/busy lookup, zero for x0 and during INIT, optional write forwarding.
  always_comb begin
    o_value = '0;
    o_busy  = 1'b0;
    if (i_state == RUN && i_addr != '0) begin
      o_value = i_regs[i_addr];
      o_busy  = i_busy[i_addr];
`ifdef REGFILE_BYPASS_EN
      // i_wr_ok already excludes x0 and INIT; later ports override earlier ones.
      for (int p = 0; p < WRITE_PORTS; p++) begin
        if (i_wr_ok[p] && i_wr_addr[p] == i_addr) begin
          o_value = i_wr_value[p];
          o_busy  = i_bset_en && (i_bset_addr == i_addr);
        end
      end
`endif
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with x0 hardwired to zero, a
// post-reset clearing sweep, and a per-register busy scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding).
// Handshake note: there is no valid/ready flow control on the ports; `ready`
// is a level that is 1 once the sweep has finished, and while it is 0 all
// writes and busy sets are ignored and all reads return zero / not busy.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WORD_WIDTH  = DEFAULT_WORD_WIDTH,
  parameter int REG_NUM     = DEFAULT_REG_NUM,
  parameter int REG_NUM_LOG = DEFAULT_REG_NUM_LOG,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  output logic                               ready,
  input  logic [WRITE_PORTS-1:0]             writeEnable,
  input  logic [WRITE_PORTS*REG_NUM_LOG-1:0] writeAddr,
  input  logic [WRITE_PORTS*WORD_WIDTH-1:0]  writeValue,
  input  logic                               busySetEnable,
  input  logic [REG_NUM_LOG-1:0]             busySetAddr,
  input  logic [READ_PORTS*REG_NUM_LOG-1:0]  readAddr,
  output logic [READ_PORTS*WORD_WIDTH-1:0]   readValue,
  output logic [READ_PORTS-1:0]              readBusy,
  output state_t                             dbg_state
);

  state_t                 r_state;
  logic [REG_NUM_LOG-1:0] r_index;
  logic                   r_ready;
  logic [WORD_WIDTH-1:0]  r_regs [REG_NUM];
  logic [REG_NUM-1:0]     r_busy;

  logic [WRITE_PORTS-1:0] w_wr_ok;
  logic [REG_NUM_LOG-1:0] w_waddr [WRITE_PORTS];
  logic [WORD_WIDTH-1:0]  w_wval [WRITE_PORTS];
  logic [REG_NUM-1:0]     w_busy_next;

  // Unpack write ports and qualify them: RUN only, never x0.
  always_comb begin
    for (int p = 0; p < WRITE_PORTS; p++) begin
      w_waddr[p] = writeAddr[slice_lo(p, REG_NUM_LOG) +: REG_NUM_LOG];
      w_wval[p]  = writeValue[slice_lo(p, WORD_WIDTH) +: WORD_WIDTH];
      w_wr_ok[p] = (r_state == RUN) && writeEnable[p] && (w_waddr[p] != '0);
    end
  end

  // Sweep FSM: index starts at 1 (x0 is never stored) and RUN begins on the
  // edge that clears the last register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INIT;
      r_index <= REG_NUM_LOG'(1);
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          r_index <= r_index + REG_NUM_LOG'(1);
          if (r_index == REG_NUM_LOG'(REG_NUM - 1)) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end
        end
        RUN:     r_state <= RUN;
        default: r_state <= INIT;
      endcase
    end
  end

  // Data array has no reset: sweep clears it, then ports write it with the
  // highest-index port overriding on a same-address conflict.
  always_ff @(posedge clk) begin
    if (r_state == INIT) begin
      r_regs[r_index] <= '0;
    end else begin
      for (int p = 0; p < WRITE_PORTS; p++) begin
        if (w_wr_ok[p]) r_regs[w_waddr[p]] <= w_wval[p];
      end
    end
  end

  // Next busy vector: accepted writes clear, a new producer set wins.
  always_comb begin
    w_busy_next = r_busy;
    if (r_state == RUN) begin
      for (int p = 0; p < WRITE_PORTS; p++) begin
        if (w_wr_ok[p]) w_busy_next[w_waddr[p]] = 1'b0;
      end
      if (busySetEnable && busySetAddr != '0) w_busy_next[busySetAddr] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  // Busy scoreboard register, cleared by the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_next;
  end

  assign ready     = r_ready;
  assign dbg_state = r_state;

  for (genvar g = 0; g < READ_PORTS; g++) begin : g_read
    regfile_read_port #(
      .WORD_WIDTH (WORD_WIDTH),
      .REG_NUM    (REG_NUM),
`ifdef REGFILE_BYPASS_EN
      .WRITE_PORTS(WRITE_PORTS),
`endif
      .REG_NUM_LOG(REG_NUM_LOG)
    ) u_read_port (
      .i_state    (r_state),
      .i_addr     (readAddr[slice_lo(g, REG_NUM_LOG) +: REG_NUM_LOG]),
      .i_regs     (r_regs),
      .i_busy     (r_busy),
`ifdef REGFILE_BYPASS_EN
      .i_wr_ok    (w_wr_ok),
      .i_wr_addr  (w_waddr),
      .i_wr_value (w_wval),
      .i_bset_en  (busySetEnable),
      .i_bset_addr(busySetAddr),
`endif
      .o_value    (readValue[slice_lo(g, WORD_WIDTH) +: WORD_WIDTH]),
      .o_busy     (readBusy[g])
    );
  end

endmodule
